// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between instruction
//   fetch (IF) and memory access (DM) of the RV32I pipeline.
//   Data wins by default; after MAX_DM_STREAK consecutive data grants with a
//   fetch waiting, the fetch is granted. A watchdog aborts any access that the
//   memory does not acknowledge, returning zero data with a bus_err pulse.
//
// Ports
//   clk, reset            : clock (rising edge), async active-high reset
//   if_req/if_addr        : fetch request (held until if_valid) and address
//   if_rdata/if_valid     : registered fetch word and one-cycle done pulse
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be : data request and command
//   dm_rdata/dm_valid     : registered load word and one-cycle done pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : registered memory command
//   mem_ready/mem_rdata   : memory completion strobe and read data
//   stall_if/stall_mem    : pipeline stalls, high while a request is unserved
//   bus_err               : pulses with the valid of a timed-out access
//   dbg_state             : current FSM state (IDLE=0, ISSUE_IF=1, ISSUE_DM=2, RESP=3)
//
// Handshake: a requester raises req with stable command fields and holds them
// until its valid pulse; fields are sampled only when the FSM is in IDLE. The
// memory side holds mem_req and the command stable until mem_ready is seen.
module mem_port_arbiter #(
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_IF = 2'd1,
    ISSUE_DM = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);
  localparam logic [7:0] WD_LIMIT   = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        dm_valid_q, dm_valid_d;
  logic        bus_err_q, bus_err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      wd_cnt_q    <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wd_cnt_q    <= wd_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    wd_cnt_d    = wd_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        wd_cnt_d = 8'd0;
        // Data wins unless a fetch has waited through a full streak.
        if (dm_req && !(if_req && streak_q == STREAK_MAX)) begin
          state_d     = ISSUE_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_be_d    = dm_be;
          if (!if_req)
            streak_d = 4'd0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + 4'd1;
        end else if (if_req) begin
          state_d     = ISSUE_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'd0;
          mem_be_d    = 4'hF;
          streak_d    = 4'd0;
        end
      end

      ISSUE_IF, ISSUE_DM: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (state_q == ISSUE_IF) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            dm_rdata_d = mem_rdata;
            dm_valid_d = 1'b1;
          end
        end else if (wd_cnt_q == WD_LIMIT) begin
          // mem_req has now been held TIMEOUT+1 cycles with no acknowledge.
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = RESP;
          if (state_q == ISSUE_IF) begin
            if_rdata_d = 32'd0;
            if_valid_d = 1'b1;
          end else begin
            dm_rdata_d = 32'd0;
            dm_valid_d = 1'b1;
          end
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end

      // One dead cycle so a requester still holding req during its valid
      // pulse is not served twice.
      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign bus_err   = bus_err_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = dm_req & ~dm_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (MAX_DM_STREAK=4, TIMEOUT=8).
// Inputs are driven and outputs sampled on the falling clock edge. Cycle 0 is
// the IDLE cycle in which a request is first presented.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory responder controls
  int          ready_delay = 0;
  logic        mem_never   = 1'b0;
  logic [31:0] rdata_val   = 32'd0;
  int          wait_cnt    = 0;

  mem_port_arbiter #(.MAX_DM_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Memory model: acknowledges after ready_delay wait cycles of mem_req.
  always @(negedge clk) begin
    if (mem_req && !mem_never) begin
      if (wait_cnt == ready_delay) begin
        mem_ready = 1'b1;
        mem_rdata = rdata_val;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0BAD0BAD;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0BAD0BAD;
      if (!mem_req) wait_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
    dm_addr = 0; dm_wdata = 0; dm_be = 0;
    mem_ready = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata,
         if_valid, dm_valid, bus_err} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs mem_addr=%h if_rdata=%h dm_rdata=%h, required all 0",
               mem_addr, if_rdata, dm_rdata);
    else n_pass++;
    n_checks++;
    if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d required 0", dbg_state);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    rdata_val = 32'h00500093; ready_delay = 0;
    if_req = 1; if_addr = 32'h100;          // cycle 0
    @(negedge clk);                          // cycle 1
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 32'h100, 4'hF})
      $display("FAIL fetch_cmd: got req=%b we=%b addr=%h be=%h required 1 0 00000100 f",
               mem_req, mem_we, mem_addr, mem_be);
    else n_pass++;
    n_checks++;
    if (stall_if !== 1'b1) $display("FAIL fetch_stall_c1: got %b required 1", stall_if);
    else n_pass++;
    @(negedge clk);                          // cycle 2
    n_checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h00500093)
      $display("FAIL fetch_resp: got valid=%b rdata=%h required 1 00500093", if_valid, if_rdata);
    else n_pass++;
    n_checks++;
    if (stall_if !== 1'b0 || dm_valid !== 1'b0)
      $display("FAIL fetch_stall_c2: got stall_if=%b dm_valid=%b required 0 0", stall_if, dm_valid);
    else n_pass++;
    if_req = 0;
    @(negedge clk);                          // cycle 3
    n_checks++;
    if (if_valid !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL fetch_pulse: got valid=%b mem_req=%b required 0 0", if_valid, mem_req);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    rdata_val = 32'h00A00113;
    if_req = 1; if_addr = 32'h200;
    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
    @(negedge clk);                          // cycle 1
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !==
        {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011})
      $display("FAIL simul_store_cmd: got we=%b addr=%h wdata=%h be=%b required 1 00002000 deadbeef 0011",
               mem_we, mem_addr, mem_wdata, mem_be);
    else n_pass++;
    n_checks++;
    if (stall_if !== 1'b1 || stall_mem !== 1'b1)
      $display("FAIL simul_stall_c1: got if=%b mem=%b required 1 1", stall_if, stall_mem);
    else n_pass++;
    @(negedge clk);                          // cycle 2
    n_checks++;
    if (dm_valid !== 1'b1 || if_valid !== 1'b0 || stall_if !== 1'b1 || stall_mem !== 1'b0)
      $display("FAIL simul_store_done: got dm_valid=%b if_valid=%b stall_if=%b stall_mem=%b required 1 0 1 0",
               dm_valid, if_valid, stall_if, stall_mem);
    else n_pass++;
    dm_req = 0; dm_we = 0;
    @(negedge clk);                          // cycle 3: IDLE
    n_checks++;
    if (mem_req !== 1'b0 || stall_if !== 1'b1)
      $display("FAIL simul_idle: got mem_req=%b stall_if=%b required 0 1", mem_req, stall_if);
    else n_pass++;
    @(negedge clk);                          // cycle 4
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b0, 32'h200, 32'h0, 4'hF})
      $display("FAIL simul_fetch_cmd: got we=%b addr=%h wdata=%h be=%h required 0 00000200 00000000 f",
               mem_we, mem_addr, mem_wdata, mem_be);
    else n_pass++;
    @(negedge clk);                          // cycle 5
    n_checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h00A00113)
      $display("FAIL simul_fetch_done: got valid=%b rdata=%h required 1 00a00113", if_valid, if_rdata);
    else n_pass++;
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic exp_dm [0:9];
    int   got;
    logic both_seen;
    exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    got = 0; both_seen = 1'b0;
    rdata_val = 32'h11110000;
    if_req = 1; if_addr = 32'h300;
    dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (if_valid && dm_valid) both_seen = 1'b1;
      if (got < 10 && (if_valid || dm_valid)) begin
        n_checks++;
        if (dm_valid !== exp_dm[got])
          $display("FAIL starve_order[%0d]: got %s required %s", got,
                   dm_valid ? "D" : "I", exp_dm[got] ? "D" : "I");
        else n_pass++;
        got++;
        if (got == 10) begin if_req = 0; dm_req = 0; end
      end
    end
    n_checks++;
    if (got != 10) $display("FAIL starve_count: got %0d grants required 10", got);
    else n_pass++;
    n_checks++;
    if (both_seen !== 1'b0) $display("FAIL starve_exclusive: got both valids high, required never");
    else n_pass++;
  endtask

  task automatic test_wait_states();
    int bad;
    bad = 0;
    rdata_val = 32'h12345678; ready_delay = 5;
    dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) dm_addr = 32'h44;         // must not disturb the access in flight
      if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || dm_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL wait_stable: got %0d unstable cycles required 0", bad);
    else n_pass++;
    @(negedge clk);                          // cycle 7
    n_checks++;
    if (dm_valid !== 1'b1 || dm_rdata !== 32'h12345678 || bus_err !== 1'b0)
      $display("FAIL wait_done: got valid=%b rdata=%h err=%b required 1 12345678 0",
               dm_valid, dm_rdata, bus_err);
    else n_pass++;
    dm_req = 0; ready_delay = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    mem_never = 1'b1;
    dm_req = 1; dm_we = 0; dm_addr = 32'h80;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (mem_req !== 1'b1 || dm_valid !== 1'b0 || bus_err !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL timeout_hold: got %0d bad cycles in 1..9 required 0", bad);
    else n_pass++;
    @(negedge clk);                          // cycle 10 = TIMEOUT+1 after mem_req rose
    n_checks++;
    if (dm_valid !== 1'b1 || bus_err !== 1'b1 || dm_rdata !== 32'h0 || mem_req !== 1'b0)
      $display("FAIL timeout_abort: got valid=%b err=%b rdata=%h mem_req=%b required 1 1 00000000 0",
               dm_valid, bus_err, dm_rdata, mem_req);
    else n_pass++;
    dm_req = 0; mem_never = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus_err !== 1'b0 || dm_valid !== 1'b0)
      $display("FAIL timeout_pulse: got err=%b valid=%b required 0 0", bus_err, dm_valid);
    else n_pass++;
    rdata_val = 32'hCAFEF00D;
    dm_req = 1; dm_addr = 32'h84;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (dm_valid !== 1'b1 || dm_rdata !== 32'hCAFEF00D || bus_err !== 1'b0)
      $display("FAIL timeout_recover: got valid=%b rdata=%h err=%b required 1 cafef00d 0",
               dm_valid, dm_rdata, bus_err);
    else n_pass++;
    dm_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    mem_never = 1'b1;
    rdata_val = 32'h0F0F0F0F;
    if_req = 1; if_addr = 32'h500;
    dm_req = 1; dm_we = 1; dm_addr = 32'h5000; dm_wdata = 32'h55AA55AA; dm_be = 4'hC;
    repeat (3) @(negedge clk);              // stuck in ISSUE_DM
    n_checks++;
    if (dbg_state !== 2'd2 || mem_req !== 1'b1)
      $display("FAIL midrst_pre: got state=%0d mem_req=%b required 2 1", dbg_state, mem_req);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata,
         if_valid, dm_valid, bus_err} !== '0 || dbg_state !== 2'd0)
      $display("FAIL midrst_outputs: got mem_req=%b mem_addr=%h if_rdata=%h dm_rdata=%h state=%0d required all 0",
               mem_req, mem_addr, if_rdata, dm_rdata, dbg_state);
    else n_pass++;
    dm_req = 0; dm_we = 0; mem_never = 1'b0;
    @(negedge clk);
    reset = 1'b0;                            // cycle 0, if_req still pending
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 32'h500, 4'hF})
      $display("FAIL midrst_fetch_cmd: got req=%b we=%b addr=%h be=%h required 1 0 00000500 f",
               mem_req, mem_we, mem_addr, mem_be);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h0F0F0F0F)
      $display("FAIL midrst_fetch_done: got valid=%b rdata=%h required 1 0f0f0f0f", if_valid, if_rdata);
    else n_pass++;
    if_req = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_wait_states();
    test_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
